// File: rtl/colnorm_pkg.sv
// rtl/colnorm_pkg.sv - shared states, widths and column-slice helpers for the H-matrix column-norm sequencer
package colnorm_pkg;

  // Sequencer states; the encoding is fixed so that debug taps stay stable across builds
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Each column carries re/im of two rows
  localparam int ELEMS_PER_COL = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_NCOL      = 2;

  // Width of one matrix column in bits
  function automatic int col_bits(input int data_w);
    return ELEMS_PER_COL * data_w;
  endfunction

  // Width of the column counter; a single-column matrix still gets a 1-bit counter
  function automatic int col_idx_w(input int ncol);
    return (ncol > 1) ? $clog2(ncol) : 1;
  endfunction

endpackage

// File: rtl/colnorm_watchdog.sv
// rtl/colnorm_watchdog.sv - WAIT-cycle watchdog that flags a norm unit that never answers
module colnorm_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Expire fires during the LIMIT-th consecutive running cycle
  assign o_expire = i_run && (r_cnt == LAST_CNT);

  // Count running cycles, restarting whenever the owner leaves the watched state
  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) begin
      r_cnt <= '0;
    end else if (i_run && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hmat_colnorm_seq.sv
// rtl/hmat_colnorm_seq.sv - issues H columns to one norm unit and collects their norms; optional watchdog via HMAT_COLNORM_TIMEOUT_EN
module hmat_colnorm_seq
  import colnorm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NCOL   = DEF_NCOL
`ifdef HMAT_COLNORM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic                                clk,
  input  logic                                reset_n,
`ifdef HMAT_COLNORM_TIMEOUT_EN
  output logic                                err,
`endif
  input  logic [NCOL*ELEMS_PER_COL*DATA_W-1:0] h_mat,
  input  logic                                enable,
  output logic                                accept_out,
  output logic                                ready_out,
  input  logic                                accept_in,
  output logic [NCOL*DATA_W-1:0]              norms,
  output logic [ELEMS_PER_COL*DATA_W-1:0]     nrm_vector,
  output logic                                nrm_enable,
  input  logic                                nrm_accept_out,
  input  logic                                nrm_ready_out,
  output logic                                nrm_accept_in,
  input  logic [DATA_W-1:0]                   nrm_res
);

  localparam int CW    = col_bits(DATA_W);
  localparam int COL_W = col_idx_w(NCOL);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NCOL - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_REQ  = REQ;
  localparam logic [1:0] ST_WAIT = WAIT;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]               r_state;
  logic [COL_W-1:0]         r_col;
  logic [NCOL*CW-1:0]       r_hmat;
  logic [NCOL*DATA_W-1:0]   r_norms;
  logic [CW-1:0]            r_vec;

  logic [COL_W-1:0]         w_col_nxt;
  logic                     w_last;
  logic                     w_cap;
  logic [CW-1:0]            w_cur_col;
  logic [CW-1:0]            w_nxt_col;
  logic                     w_expire;

  assign w_col_nxt = r_col + 1'b1;
  assign w_last    = (r_col == LAST_COL);
  assign w_cap     = (r_state == ST_WAIT) && nrm_ready_out;
  assign w_cur_col = r_hmat[int'(r_col) * CW +: CW];
  assign w_nxt_col = r_hmat[int'(w_col_nxt) * CW +: CW];

  assign accept_out = (r_state == ST_IDLE);
  assign ready_out  = (r_state == ST_DONE);
  assign nrm_enable = (r_state == ST_REQ) && nrm_accept_out;
  assign norms      = r_norms;
  assign nrm_vector = r_vec;

`ifdef HMAT_COLNORM_TIMEOUT_EN
  logic r_err;

  assign err = r_err;

  // Outside an active request a late result is drained so the norm unit can go idle again
  assign nrm_accept_in = nrm_ready_out &&
                         ((r_state == ST_WAIT) || (r_state == ST_IDLE) || (r_state == ST_DONE));

  colnorm_watchdog #(
    .LIMIT(TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (r_state != ST_WAIT),
    .i_run   (r_state == ST_WAIT),
    .o_expire(w_expire)
  );

  // Error flag: raised on watchdog expiry, cleared only when a new matrix is accepted
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_IDLE) && enable) begin
      r_err <= 1'b0;
    end else if (w_expire && !w_cap) begin
      r_err <= 1'b1;
    end
  end
`else
  assign nrm_accept_in = w_cap;
  assign w_expire      = 1'b0;
`endif

  // Sequencer: latch matrix, walk the columns through the norm unit, hold norms until consumed
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_col   <= '0;
      r_hmat  <= '0;
      r_norms <= '0;
      r_vec   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_hmat  <= h_mat;
            r_col   <= '0;
            // Column 0 is presented from the first REQ cycle onward
            r_vec   <= h_mat[CW-1:0];
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_vec <= w_cur_col;
          if (nrm_accept_out) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // r_vec is left untouched: the norm unit keeps reading it until it answers
          if (w_cap) begin
            r_norms[int'(r_col) * DATA_W +: DATA_W] <= nrm_res;
            if (w_last) begin
              r_state <= ST_DONE;
            end else begin
              r_col   <= w_col_nxt;
              r_vec   <= w_nxt_col;
              r_state <= ST_REQ;
            end
          end else if (w_expire) begin
            // Abandon this and every later column so no stale norm survives
            for (int c = 0; c < NCOL; c++) begin
              if (c >= int'(r_col)) begin
                r_norms[c * DATA_W +: DATA_W] <= '0;
              end
            end
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (accept_in) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
